// File: rtl/bt_pipe_out_fifo.sv
// Block-throttled pipe-out source buffer: user pushes words, the host pops whole blocks.
// Optional partial-block release via the flush input is built when BT_PIPE_OUT_FLUSH_EN is defined.
module bt_pipe_out_fifo #(
  parameter int DEPTH       = 1024,
  parameter int BLOCK_WORDS = 256,
  parameter int CW          = $clog2(DEPTH) + 1
) (
  input  logic          ti_clk,
  input  logic          ti_reset,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  output logic          full,
  output logic [CW-1:0] fill,
  output logic          ep_ready,
  input  logic          ep_blockstrobe,
  input  logic          ep_read,
  output logic [31:0]   ep_datain,
`ifdef BT_PIPE_OUT_FLUSH_EN
  input  logic          flush,
`endif
  output logic          overflow,
  output logic          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(BLOCK_WORDS + 1);
  localparam logic [CW-1:0] FILL_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] BLK_FILL  = CW'(BLOCK_WORDS);
  localparam logic [WW-1:0] WCNT_LOAD = WW'(BLOCK_WORDS);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [WW-1:0] wcnt;
  logic          flush_pend;

  logic do_pop;
  logic do_zero;
  logic do_push;
  logic blk_start;
  logic blk_step;
  logic blk_last;
  logic rd_bad;
  logic ready_nxt;

  assign full = (fill == FILL_MAX);

  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (blk_start) state_nxt = S_BURST;
      S_BURST: if (blk_last)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A read in a flushed block past the buffered data returns zero but still counts.
  always_comb begin
    do_pop    = ep_read && (state == S_BURST) && (fill != '0);
    do_zero   = ep_read && (state == S_BURST) && (fill == '0) && flush_pend;
    do_push   = wr_en && (!full || do_pop);
    blk_start = (state == S_IDLE) && ep_blockstrobe && ep_ready;
    blk_step  = do_pop || do_zero;
    blk_last  = blk_step && (wcnt == WW'(1));
    rd_bad    = ep_read && !blk_step;
    ready_nxt = (state == S_IDLE) && !blk_start && ((fill >= BLK_FILL) || flush_pend);
  end

  always_ff @(posedge ti_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      wcnt      <= '0;
      ep_ready  <= 1'b0;
      ep_datain <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + CW'(1);
        2'b01:   fill <= fill - CW'(1);
        default: fill <= fill;
      endcase
      if (do_pop)       ep_datain <= mem[rd_ptr];
      else if (do_zero) ep_datain <= '0;
      if (blk_start)     wcnt <= WCNT_LOAD;
      else if (blk_step) wcnt <= wcnt - WW'(1);
      ep_ready <= ready_nxt;
      if (wr_en && !do_push) overflow  <= 1'b1;
      if (rd_bad)            underflow <= 1'b1;
    end
  end

`ifdef BT_PIPE_OUT_FLUSH_EN
  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset)
      flush_pend <= 1'b0;
    else if (blk_last)
      flush_pend <= 1'b0;
    else if ((state == S_IDLE) && flush && (fill != '0) && (fill < BLK_FILL))
      flush_pend <= 1'b1;
  end
`else
  assign flush_pend = 1'b0;
`endif

endmodule

// File: tb/tb_bt_pipe_out_fifo.sv
// Bench for bt_pipe_out_fifo: queue-based reference model, expected-read scoreboard, random burst traffic.
module tb_bt_pipe_out_fifo;
  localparam int DEPTH = 1024;
  localparam int BW    = 256;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef BT_PIPE_OUT_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic          ti_clk = 1'b0;
  logic          ti_reset;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          full;
  logic [CW-1:0] fill;
  logic          ep_ready;
  logic          ep_blockstrobe;
  logic          ep_read;
  logic [31:0]   ep_datain;
  logic          overflow;
  logic          underflow;
`ifdef BT_PIPE_OUT_FLUSH_EN
  logic          flush;
`endif

  bt_pipe_out_fifo #(.DEPTH(DEPTH), .BLOCK_WORDS(BW)) dut (
    .ti_clk(ti_clk), .ti_reset(ti_reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .fill(fill), .ep_ready(ep_ready), .ep_blockstrobe(ep_blockstrobe),
    .ep_read(ep_read), .ep_datain(ep_datain),
`ifdef BT_PIPE_OUT_FLUSH_EN
    .flush(flush),
`endif
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  always #5 ti_clk = ~ti_clk;

  // reference model: buffered words as a plain queue plus block bookkeeping
  logic [31:0] mdl_q[$];
  logic [31:0] exp_q[$];
  bit          m_burst;
  int          m_left;
  bit          m_pend;
  bit          m_of;
  bit          m_uf;
  logic [31:0] m_last;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic bit m_ready();
    return !m_burst && ((mdl_q.size() >= BW) || m_pend);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    exp_q.delete();
    m_burst = 0; m_left = 0; m_pend = 0; m_of = 0; m_uf = 0; m_last = '0;
  endtask

  // driver: one call = inputs for one clock edge, model advanced for that edge
  task automatic step(input bit wr, input logic [31:0] d, input bit rd, input bit bs, input bit fl);
    bit pop, zero, push_ok, start, set_pend;
    logic [31:0] dv;
    @(posedge ti_clk); #1;
    wr_en = wr; wr_data = d; ep_read = rd; ep_blockstrobe = bs;
`ifdef BT_PIPE_OUT_FLUSH_EN
    flush = fl;
`endif
    pop      = rd && m_burst && (mdl_q.size() > 0);
    zero     = rd && m_burst && (mdl_q.size() == 0) && m_pend;
    push_ok  = wr && ((mdl_q.size() < DEPTH) || pop);
    start    = bs && m_ready();
    set_pend = FLUSH_EN && fl && !m_burst && (mdl_q.size() > 0) && (mdl_q.size() < BW);
    if (rd && !pop && !zero) m_uf = 1;
    if (wr && !push_ok) m_of = 1;
    if (rd) begin
      dv = pop ? mdl_q[0] : (zero ? 32'h0 : m_last);
      exp_q.push_back(dv);
      m_last = dv;
    end
    if (pop) void'(mdl_q.pop_front());
    if (push_ok) mdl_q.push_back(d);
    if (m_burst && (pop || zero)) begin
      m_left--;
      if (m_left == 0) begin m_burst = 0; m_pend = 0; end
    end else if (start) begin
      m_burst = 1; m_left = BW;
    end
    if (set_pend) m_pend = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, 0, 0);
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(1, base + 32'(i), 0, 0, 0);
  endtask

  task automatic check_status(input string tag);
    idle(2);
    @(negedge ti_clk);
    chk({tag, " fill"}, 64'(fill), 64'(mdl_q.size()));
    chk({tag, " full"}, 64'(full), 64'(mdl_q.size() == DEPTH));
    chk({tag, " ep_ready"}, 64'(ep_ready), 64'(m_ready()));
    chk({tag, " overflow"}, 64'(overflow), 64'(m_of));
    chk({tag, " underflow"}, 64'(underflow), 64'(m_uf));
  endtask

  task automatic start_block(input string tag);
    idle(2);
    @(negedge ti_clk);
    chk({tag, " ready at strobe"}, 64'(ep_ready), 64'(m_ready()));
    step(0, '0, 0, 1, 0);
  endtask

  task automatic drain_block(input string tag);
    start_block(tag);
    for (int i = 0; i < BW; i++) begin
      step(0, '0, 1, 0, 0);
      @(negedge ti_clk);
      if (i > 0) chk({tag, " ready in burst"}, 64'(ep_ready), 64'(0));
    end
    idle(1);
  endtask

  // monitor: every edge that sampled ep_read produces one ep_datain check
  logic rd_at_edge;
  always @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset) rd_at_edge <= 1'b0;
    else          rd_at_edge <= ep_read;
  end

  initial begin
    forever begin
      @(negedge ti_clk);
      if (rd_at_edge) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL ep_datain: read with no expected entry, got %0h (t=%0t)", ep_datain, $time);
        end else begin
          chk("ep_datain", 64'(ep_datain), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int guard;
    bit b;
    ti_reset = 1; wr_en = 0; wr_data = '0; ep_read = 0; ep_blockstrobe = 0;
`ifdef BT_PIPE_OUT_FLUSH_EN
    flush = 0;
`endif
    model_reset();
    #12;
    chk("reset full", 64'(full), 64'(0));
    chk("reset fill", 64'(fill), 64'(0));
    chk("reset ep_ready", 64'(ep_ready), 64'(0));
    chk("reset ep_datain", 64'(ep_datain), 64'(0));
    chk("reset overflow", 64'(overflow), 64'(0));
    chk("reset underflow", 64'(underflow), 64'(0));
    #10 ti_reset = 0;

    // threshold: 255 words is not a block, the 256th raises ep_ready one cycle later
    push_n(BW - 1, 32'd0);
    check_status("p255");
    step(1, 32'(BW - 1), 0, 0, 0);
    step(0, '0, 0, 0, 0);
    @(negedge ti_clk);
    chk("p256 fill", 64'(fill), 64'(BW));
    chk("p256 ready same cycle", 64'(ep_ready), 64'(0));
    step(0, '0, 0, 0, 0);
    @(negedge ti_clk);
    chk("p256 ready next cycle", 64'(ep_ready), 64'(1));

    // one block 0..255
    drain_block("blk0");
    check_status("after blk0");

    // overflow, four blocks, then refill across the pointer wrap
    push_n(DEPTH + 1, 32'd0);
    check_status("overfill");
    for (int k = 0; k < 4; k++) drain_block("ovf drain");
    check_status("ovf drained");
    push_n(DEPTH, 32'h5000);
    check_status("refill");
    for (int k = 0; k < 4; k++) drain_block("wrap drain");
    check_status("wrap drained");

    // random concurrent push/pop inside a burst, stray strobes ignored
    for (int i = 0; i < BW; i++) step(1, $urandom, 0, 0, 0);
    start_block("conc");
    guard = 0;
    while (m_burst && guard < 2000) begin
      b = 1'($urandom_range(0, 1));
      step(b, $urandom, b, m_burst && ($urandom_range(0, 3) == 0), 0);
      guard++;
    end
    if (m_burst) begin
      n_cmp++; n_err++;
      $display("FAIL conc burst: block did not finish within %0d cycles", guard);
    end
    check_status("conc");
    drain_block("conc tail");
    check_status("conc done");

    // idle read, strobe without a block
    step(0, '0, 1, 0, 0);
    push_n(10, 32'hA0);
    start_block("strobe10");
    check_status("strobe10");
    step(0, '0, 1, 0, 0);
    check_status("idle read10");

    // reset in the middle of a burst
    push_n(BW - 10, 32'hB0);
    start_block("rst blk");
    for (int i = 0; i < 20; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    @(negedge ti_clk); #2;
    ti_reset = 1; #1;
    chk("midrst full", 64'(full), 64'(0));
    chk("midrst fill", 64'(fill), 64'(0));
    chk("midrst ep_ready", 64'(ep_ready), 64'(0));
    chk("midrst ep_datain", 64'(ep_datain), 64'(0));
    chk("midrst overflow", 64'(overflow), 64'(0));
    chk("midrst underflow", 64'(underflow), 64'(0));
    chk("midrst pending reads", 64'(exp_q.size()), 64'(0));
    model_reset();
    @(posedge ti_clk); #3 ti_reset = 0;
    check_status("post rst");

    // partial block
    push_n(5, 32'd1);
    step(0, '0, 0, 0, 1);
    check_status("partial");
    if (FLUSH_EN) begin
      drain_block("flush blk");
      check_status("flush done");
    end

    idle(1);
    @(negedge ti_clk); #2;
    chk("leftover expected reads", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bt_pipe_out_fifo.md
Name: bt_pipe_out_fifo

Overview:
- Synthesizable block-throttled source buffer feeding the ep_* side of a block-throttled pipe-out endpoint; it is the transmit counterpart of the block-throttled pipe-in path.
- User logic pushes 32-bit words into an internal FIFO.
- The block raises ep_ready only when one full block is buffered, then pops exactly one block as the host issues reads.
- Everything runs in the ti_clk domain.

Parameters:
- DEPTH, 1024, FIFO depth in 32-bit words; power of two; must be >= BLOCK_WORDS.
- BLOCK_WORDS, 256, words per host block transfer; must be >= 1.
- CW, $clog2(DEPTH)+1, width of the fill counter.

Ports:
- ti_clk  in  1  host-interface clock; all logic on its rising edge.
- ti_reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  user push strobe.
- wr_data  in  32  user word.
- full  out  1  FIFO holds DEPTH words.
- fill  out  CW  current FIFO word count.
- ep_ready  out  1  one block is available to the host.
- ep_blockstrobe  in  1  one-cycle pulse from the endpoint; a block transfer starts.
- ep_read  in  1  endpoint read strobe, one per word.
- ep_datain  out  32  word returned to the endpoint.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: ep_read arrived outside a block or with the FIFO empty.

Behaviour:
- Reset values: every output is 0, the FIFO is empty, state is IDLE, and the sticky flags are cleared. Reset asserted mid-block aborts the block and discards all data.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - fill equals writes minus reads and is updated on the same edge as the push or pop.
  - full = (fill == DEPTH).
- Push: on wr_en with full=0, wr_data is stored. On wr_en with full=1, the word is dropped and overflow is set.
- Pop latency: ep_read sampled high in BURST with fill>0 pops the head word. ep_datain carries that word from the same edge and holds it until the next pop.
- Simultaneous push and pop: both take effect and fill is unchanged. A push at fill==DEPTH together with a pop is accepted.
- State machine:
  - IDLE:
    - ep_ready = (fill >= BLOCK_WORDS), registered one cycle after fill changes.
    - ep_blockstrobe while ep_ready=1: load word counter wcnt=BLOCK_WORDS, go to BURST, ep_ready=0 on the next edge.
    - ep_blockstrobe while ep_ready=0: ignored.
    - ep_read: ignored for data; underflow is set.
  - BURST:
    - ep_ready=0.
    - Each ep_read pops one word and decrements wcnt.
    - When wcnt would reach 0, go to IDLE. ep_ready may reassert on the following cycle if fill >= BLOCK_WORDS.
    - ep_blockstrobe in BURST is ignored.
    - ep_read with fill==0 (not reachable in correct use): no pop, ep_datain holds, wcnt is unchanged, underflow is set.
- The sticky flags clear only on ti_reset.

Optional Feature:
- Macro: BT_PIPE_OUT_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - A flush pulse in IDLE with 0 < fill < BLOCK_WORDS sets a pending flag, and ep_ready asserts.
  - The following block pops the remaining words. Reads beyond the buffered data return 32'h0000_0000 and count toward wcnt without setting underflow.
  - The pending flag clears when the block ends. A flush with fill==0 or fill>=BLOCK_WORDS has no effect.
- Undefined: no flush port; a partial block is never released.

Test Plan:
- Reset, then push 255 words with BLOCK_WORDS=256 -> ep_ready=0. Push a 256th word -> ep_ready=1 the next cycle, fill=256.
- Push 0..255, pulse ep_blockstrobe, then 256 consecutive ep_read -> ep_datain = 0,1,...,255 on successive edges, ep_ready=0 during the burst, fill=0 and state IDLE afterwards.
- DEPTH=1024: push 1025 words -> full=1, overflow=1, fill=1024. Drain four blocks -> data 0..1023 in order; pointer wrap verified by refilling with 1024 new words.
- During a burst, wr_en and ep_read asserted on the same cycles -> fill constant and no word lost or duplicated.
- ep_read in IDLE, and ep_blockstrobe with fill=10 -> underflow=1, no state change, fill=10. Assert ti_reset mid-burst -> all outputs 0 immediately, FIFO empty.
- With BT_PIPE_OUT_FLUSH_EN: push 5 words (values 1..5), pulse flush -> ep_ready=1. A 256-read block returns 1..5 then 251 zeros, underflow=0.
